debug_spi_transmitter: RTL and testbench
========================================

DEBUG_SPI_TRANSMITTER -- requirements
Module: debug_spi_transmitter

Interface
REQ-001 Parameters SHALL be: WORD_WIDTH, default 16, bits per SPI word; SCK_HALF, default 2, clk cycles per SCK half-period (minimum 1).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_request  input  1  push request (level), word to send is valid.
REQ-006 Port in_data  input  WORD_WIDTH  word to transmit.
REQ-007 Port in_done  output  1  one-cycle acknowledge: word accepted.
REQ-008 Port rd_request  output  1  one-cycle strobe: received word valid.
REQ-009 Port rd_data  output  WORD_WIDTH  word shifted in from miso.
REQ-010 Port nCS  output  1  SPI chip select, active low.
REQ-011 Port sck  output  1  SPI clock, idle low (mode 0).
REQ-012 Port mosi  output  1  serial data out, MSB first.
REQ-013 Port miso  input  1  serial data in, MSB first.

Function
REQ-014 The block SHALL be an SPI master that sends one WORD_WIDTH-bit word per accepted push and returns the simultaneously received word.
REQ-015 States SHALL be IDLE, SETUP, HIGH, LOW, DONE and GAP.
REQ-016 IDLE: nCS=1, sck=0, mosi=0; when in_request=1, latch in_data into the tx shift register, clear the rx shift register and bit counter, pulse in_done for exactly that cycle, and go to SETUP.
REQ-017 SETUP: nCS=0, sck=0, mosi=tx MSB, held SCK_HALF cycles, then go to HIGH.
REQ-018 HIGH: sck=1 for SCK_HALF cycles; miso SHALL be shifted into the rx register LSB end on the first cycle of HIGH (rising SCK edge).
REQ-019 LOW: sck=0 for SCK_HALF cycles; on its first cycle the tx register shifts left one bit so mosi presents the next bit; after the WORD_WIDTH-th HIGH phase go to DONE instead of LOW.
REQ-020 Bit order SHALL be MSB first on both mosi and miso; mosi SHALL change only while sck=0.
REQ-021 DONE: nCS=0, sck=0; rd_data SHALL be loaded with the rx register and rd_request pulsed high for exactly one cycle; then go to GAP.
REQ-022 GAP: nCS=1, sck=0 for 2*SCK_HALF cycles, then return to IDLE.
REQ-023 rd_data SHALL hold its value until the next DONE.
REQ-024 in_request SHALL be sampled only in IDLE; a request asserted while busy SHALL stall without in_done until IDLE is reached.
REQ-025 in_request still high when IDLE is re-entered SHALL be treated as a new word; the source must drop it within WORD_WIDTH*2*SCK_HALF cycles of in_done.
REQ-026 in_data SHALL be ignored except in the accept cycle.
REQ-027 Back-to-back requests SHALL produce one nCS-low frame per word, separated by the GAP.

Reset
REQ-028 When rst=1 at a clk edge, the state SHALL become IDLE with nCS=1, sck=0, mosi=0, in_done=0, rd_request=0, rd_data=0, and shift registers and counters cleared.
REQ-029 Reset mid-transfer SHALL abort the word without a rd_request pulse; the aborted word is not resent.

Verification
REQ-030 Reset: assert rst 2 cycles -> nCS=1, sck=0, mosi=0, in_done=0, rd_request=0, rd_data=0.
REQ-031 Single word 16'hAB00 with miso looped to mosi -> in_done pulses once; mosi bits 1010101100000000 on rising sck edges; exactly 16 sck pulses in one nCS-low frame; rd_request pulses once with rd_data=16'hAB00.
REQ-032 Packet AB00, 02A2, EFAB, 0001, 9D4E, 0000 pushed back-to-back -> six frames in order, six in_done pulses, six rd_request pulses with loopback data equal to each word, nCS high for 2*SCK_HALF cycles between frames.
REQ-033 miso tied 1, send 16'h0000 -> mosi stays 0 throughout; rd_data=16'hFFFF.
REQ-034 in_request raised during a transfer -> no in_done until GAP ends; the word is then accepted on the first IDLE cycle.
REQ-035 rst asserted after 5 bits of 16'h1234 -> next cycle nCS=1, sck=0, no rd_request; a following push of 16'h5678 completes normally with rd_data equal to its loopback value.

Source files
------------

// File: rtl/debug_spi_transmitter.sv
// Mode-0 SPI master: sends one word per accepted push (MSB first) and returns
// the word shifted in from miso, with a fixed chip-select gap between frames.
module debug_spi_transmitter #(
  parameter int WORD_WIDTH = 16,
  parameter int SCK_HALF   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_request,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_done,
  output logic                  rd_request,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  nCS,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = $clog2(2 * SCK_HALF + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * SCK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE, GAP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WORD_WIDTH-1:0] tx_q, tx_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d;
  logic [WORD_WIDTH-1:0] rd_data_d;

  // NOTE: state is updated with non-blocking assignments only; the combinational
  // block below uses blocking assignments so later lines see earlier results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_data <= rd_data_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data;
    nCS        = 1'b1;
    sck        = 1'b0;
    mosi       = 1'b0;
    in_done    = 1'b0;
    rd_request = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_request && !rst) begin
          tx_d    = in_data;
          rx_d    = '0;
          bit_d   = '0;
          cnt_d   = '0;
          in_done = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        nCS  = 1'b0;
        mosi = tx_q[WORD_WIDTH-1];
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        nCS  = 1'b0;
        sck  = 1'b1;
        mosi = tx_q[WORD_WIDTH-1];
        if (cnt_q == '0) rx_d = {rx_q[WORD_WIDTH-2:0], miso};
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + BW'(1);
          // rx_d already includes this phase's sample, even when SCK_HALF is 1.
          if (bit_q == BIT_LAST) begin
            rd_data_d = rx_d;
            state_d   = DONE;
          end else begin
            tx_d    = {tx_q[WORD_WIDTH-2:0], 1'b0};
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOW: begin
        nCS  = 1'b0;
        mosi = tx_q[WORD_WIDTH-1];
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        nCS        = 1'b0;
        rd_request = 1'b1;
        cnt_d      = '0;
        state_d    = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debug_spi_transmitter.sv
// Self-checking bench for debug_spi_transmitter: directed scenarios plus random
// words, checked by a bus monitor that rebuilds each frame from the SPI pins.
module tb_debug_spi_transmitter;

  localparam int W  = 16;
  localparam int SH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_request = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_done, rd_request, nCS, sck, mosi, miso;
  logic [W-1:0] rd_data;
  logic         miso_drv = 1'b0;
  int           miso_mode = 0;   // 0 loopback, 1 tied high, 2 random

  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? mosi : miso_drv;

  debug_spi_transmitter #(.WORD_WIDTH(W), .SCK_HALF(SH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_request (in_request),
    .in_data    (in_data),
    .in_done    (in_done),
    .rd_request (rd_request),
    .rd_data    (rd_data),
    .nCS        (nCS),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave-side miso source; only changes while sck is low.
  always @(negedge clk) begin
    if (miso_mode == 1)                miso_drv <= 1'b1;
    else if (miso_mode == 2 && !sck)   miso_drv <= 1'($urandom);
    else if (miso_mode == 0)           miso_drv <= 1'b0;
  end

  // Reference model: a frame is the bits seen on mosi/miso at each sck rise
  // while nCS is low; accepted words are queued and must appear in order.
  int           cyc = 0;
  bit           in_frame = 0;
  int           sck_rises = 0;
  logic [W-1:0] mosi_acc = '0, miso_acc = '0;
  logic         prev_sck = 0, prev_mosi = 0, prev_ncs = 1;
  logic         frame_mosi_or = 0, last_mosi_or = 0;
  int           hi_len = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rd_log[$];
  int           gaps[$];
  int           done_cnt = 0, rdreq_cnt = 0;
  int           last_rd_cyc = 0, last_done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame  = 0;
      sck_rises = 0;
      exp_q.delete();
      prev_sck  = 0;
      prev_mosi = 0;
      prev_ncs  = 1;
      hi_len    = 0;
    end else begin
      if (in_done) begin
        done_cnt++;
        exp_q.push_back(in_data);
        last_done_cyc = cyc;
        sck_rises = 0;
      end
      if (!nCS && prev_ncs) begin
        in_frame      = 1;
        sck_rises     = 0;
        mosi_acc      = '0;
        miso_acc      = '0;
        frame_mosi_or = 0;
        gaps.push_back(hi_len);
      end
      if (nCS) begin
        hi_len++;
        check("sck_idle_when_deselected", sck, 1'b0);
      end else begin
        hi_len = 0;
        frame_mosi_or |= mosi;
      end
      if (sck && !prev_sck) begin
        sck_rises++;
        mosi_acc = {mosi_acc[W-2:0], mosi};
        miso_acc = {miso_acc[W-2:0], miso};
      end
      if (sck && prev_sck) check("mosi_stable_while_sck_high", mosi, prev_mosi);
      if (rd_request) begin
        rdreq_cnt++;
        last_rd_cyc = cyc;
        rd_log.push_back(rd_data);
        check("rd_data_vs_miso_bits", rd_data, miso_acc);
        check("bits_before_rd_request", sck_rises, W);
      end
      if (nCS && !prev_ncs && in_frame) begin
        in_frame     = 0;
        last_mosi_or = frame_mosi_or;
        check("sck_pulses_per_frame", sck_rises, W);
        check("pending_words_at_frame_end", exp_q.size(), 1);
        if (exp_q.size() > 0) check("mosi_word", mosi_acc, exp_q.pop_front());
      end
      prev_sck  = sck;
      prev_mosi = mosi;
      prev_ncs  = nCS;
    end
  end

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = in_done;
    end
    check({tag, "_in_done_seen"}, seen, 1'b1);
  endtask

  task automatic wait_rd(input int target);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (rdreq_cnt >= target);
    end
    check("rd_request_seen", seen, 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int target;
    target = rdreq_cnt + 1;
    @(posedge clk); #1;
    in_request = 1'b1;
    in_data    = w;
    wait_done("accept");
    @(posedge clk); #1;
    in_request = 1'b0;
    in_data    = W'($urandom);
    wait_rd(target);
    repeat (2 * SH + 2) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] pkt [6] = '{16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4E, 16'h0000};

  initial begin
    int d0, r0, d1, r1;
    bit seen;
    logic [W-1:0] w;
    int mode;

    // Reset with a request pending: no acknowledge while rst is high.
    in_request = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ncs", nCS, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_in_done", in_done, 1'b0);
    check("rst_rd_request", rd_request, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    in_request = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_accept_after_rst", done_cnt, 0);

    // Single loopback word.
    d0 = done_cnt; r0 = rdreq_cnt;
    send_word(16'hAB00);
    check("single_in_done_count", done_cnt - d0, 1);
    check("single_rd_count", rdreq_cnt - r0, 1);
    check("single_rd_data", rd_data, 16'hAB00);

    // Back-to-back packet with request held high.
    d0 = done_cnt; r0 = rdreq_cnt;
    gaps.delete(); rd_log.delete();
    @(posedge clk); #1;
    in_request = 1'b1;
    in_data    = pkt[0];
    for (int k = 0; k < 6; k++) begin
      wait_done("pkt_accept");
      @(posedge clk); #1;
      if (k < 5) in_data = pkt[k+1];
      else begin
        in_request = 1'b0;
        in_data    = W'($urandom);
      end
    end
    wait_rd(r0 + 6);
    repeat (2 * SH + 2) @(posedge clk);
    #1;
    check("pkt_in_done_count", done_cnt - d0, 6);
    check("pkt_rd_count", rdreq_cnt - r0, 6);
    check("pkt_rd_log_size", rd_log.size(), 6);
    for (int k = 0; k < 6 && k < rd_log.size(); k++) check("pkt_rd_data", rd_log[k], pkt[k]);
    // Deselect time between frames is GAP plus the IDLE cycle that accepts the next word.
    for (int k = 1; k < 6 && k < gaps.size(); k++) check("pkt_ncs_gap", gaps[k], 2 * SH + 1);

    // miso tied high, all-zero word.
    miso_mode = 1;
    send_word(16'h0000);
    check("miso_high_rd_data", rd_data, 16'hFFFF);
    check("miso_high_mosi_quiet", last_mosi_or, 1'b0);
    miso_mode = 0;

    // Request raised mid-transfer stalls until GAP has elapsed.
    r0 = rdreq_cnt;
    @(posedge clk); #1;
    in_request = 1'b1;
    in_data    = 16'h5A5A;
    wait_done("stall_first");
    @(posedge clk); #1;
    in_request = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    in_request = 1'b1;
    in_data    = 16'hC3C3;
    d1 = done_cnt;
    wait_done("stall_second");
    check("stall_rd_before_accept", rdreq_cnt - r0, 1);
    check("stall_single_accept", done_cnt - d1, 1);
    check("stall_accept_latency", last_done_cyc - last_rd_cyc, 2 * SH + 1);
    @(posedge clk); #1;
    in_request = 1'b0;
    wait_rd(r0 + 2);
    repeat (2 * SH + 2) @(posedge clk);
    #1;
    check("stall_rd_data", rd_data, 16'hC3C3);

    // Reset after five bits aborts the word.
    @(posedge clk); #1;
    in_request = 1'b1;
    in_data    = 16'h1234;
    wait_done("abort_accept");
    @(posedge clk); #1;
    in_request = 1'b0;
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (sck_rises >= 5);
    end
    check("abort_reached_bit5", seen, 1'b1);
    r1 = rdreq_cnt; d1 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("abort_ncs", nCS, 1'b1);
    check("abort_sck", sck, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    check("abort_rd_request", rd_request, 1'b0);
    check("abort_rd_data", rd_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_rd_request", rdreq_cnt - r1, 0);
    check("abort_not_resent", done_cnt - d1, 0);
    check("abort_ncs_idle", nCS, 1'b1);
    send_word(16'h5678);
    check("after_abort_rd_data", rd_data, 16'h5678);

    // Random words, random miso source, random idle spacing.
    for (int n = 0; n < 24; n++) begin
      mode = int'($urandom_range(0, 2));
      miso_mode = mode;
      w = W'($urandom);
      send_word(w);
      if (mode == 0) check("rand_loopback_rd_data", rd_data, w);
      if (mode == 1) check("rand_miso_high_rd_data", rd_data, 16'hFFFF);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      @(negedge clk); #1;
      if (rd_log.size() > 0) check("rand_rd_data_hold", rd_data, rd_log[$]);
    end
    miso_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
